// File: rtl/pc_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq_pkg
//  Purpose  : Shared constants and state encoding for the fetch sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

  // Default vectors and sequential step size
  localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] c_TRAP_VECTOR  = 32'h0000_0100;
  localparam logic [31:0] c_INSTR_BYTES  = 32'd4;

  // Fetch controller state encoding
  localparam logic [2:0] c_ST_BOOT  = 3'd0;
  localparam logic [2:0] c_ST_FETCH = 3'd1;
  localparam logic [2:0] c_ST_ISSUE = 3'd2;
  localparam logic [2:0] c_ST_DRAIN = 3'd3;
  localparam logic [2:0] c_ST_IDLE  = 3'd4;

  typedef enum logic [2:0] {
    S_BOOT  = c_ST_BOOT,
    S_FETCH = c_ST_FETCH,
    S_ISSUE = c_ST_ISSUE,
    S_DRAIN = c_ST_DRAIN,
    S_IDLE  = c_ST_IDLE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_sequencer_if
//  Purpose  : Instruction-memory request/ack port and decode valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_sequencer_if;

  // Instruction memory side
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Decode side
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  // Fetch sequencer drives requests and instructions
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr, instr_pc, instr_valid,
    input  instr_ready
  );

  // Memory / decode environment
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr, instr_pc, instr_valid,
    output instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_sequencer
//  Purpose  : Fetch-stage controller. Sequences the PC register, runs a
//             single-outstanding imem handshake and hands fetched words to
//             decode. Handles redirects, traps and counts delivered words.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = c_TRAP_VECTOR,
  parameter logic [31:0] INSTR_BYTES  = c_INSTR_BYTES
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic [31:0]                 pc_cur,
  output logic [31:0]                 pc_next,
  output logic                        pc_write,
  pc_fetch_sequencer_if.master        bus,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_target,
  input  logic                        trap,
  output logic                        misalign_err,
  input  logic                        halt,
  output logic [31:0]                 fetch_count
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic [31:0] r_fetch_count;
  logic [31:0] r_drain_addr;

  logic        w_flush;
  logic        w_misalign;
  logic [31:0] w_flush_pc;
  logic        w_req;
  logic        w_accept;
  logic [31:0] w_seq_pc;
  logic        w_pc_write;
  logic [31:0] w_pc_next;
  logic        w_load_instr;
  logic        w_count_en;

  // A redirect or trap is honoured everywhere except the boot cycle
  assign w_flush    = (r_state != S_BOOT) && (trap || redirect_valid);
  assign w_misalign = (r_state != S_BOOT) && !trap && redirect_valid &&
                      (redirect_target[1:0] != 2'b00);
  assign w_flush_pc = (trap || w_misalign) ? TRAP_VECTOR : redirect_target;
  assign w_req      = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_accept   = (r_state == S_ISSUE) && r_instr_valid && bus.instr_ready;
  assign w_seq_pc   = pc_cur + INSTR_BYTES;

  // Next-state and PC-write decode; flush overrides the sequential path
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_write   = 1'b0;
    w_pc_next    = 32'h0;
    w_load_instr = 1'b0;
    w_count_en   = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_pc_write  = 1'b1;
        w_pc_next   = RESET_VECTOR;
        w_state_nxt = halt ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          w_pc_write   = 1'b1;
          w_pc_next    = w_seq_pc;
          w_load_instr = 1'b1;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_accept) begin
          w_count_en  = 1'b1;
          w_state_nxt = halt ? S_IDLE : S_FETCH;
        end
      end
      S_IDLE: begin
        if (!halt) w_state_nxt = S_FETCH;
      end
      S_DRAIN: begin
        if (bus.imem_ack) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_BOOT;
    endcase
    if (w_flush) begin
      w_pc_write   = 1'b1;
      w_pc_next    = w_flush_pc;
      w_load_instr = 1'b0;
      w_count_en   = 1'b0;
      if (w_req && !bus.imem_ack)
        w_state_nxt = S_DRAIN;     // request still in flight, must swallow its ack
      else if (w_req)
        w_state_nxt = S_FETCH;     // in-flight data arrives now and is dropped
      else
        w_state_nxt = halt ? S_IDLE : S_FETCH;
    end
  end

  // State register
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= S_BOOT;
    else      r_state <= w_state_nxt;
  end

  // Decode-side instruction register and its valid flag
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
      r_instr_valid <= 1'b0;
    end else if (w_load_instr) begin
      r_instr       <= bus.imem_rdata;
      r_instr_pc    <= pc_cur;
      r_instr_valid <= 1'b1;
    end else if (w_flush || w_count_en) begin
      r_instr_valid <= 1'b0;
    end
  end

  // Delivered-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge res) begin
    if (!res)            r_fetch_count <= 32'h0;
    else if (w_count_en) r_fetch_count <= r_fetch_count + 32'd1;
  end

  // Holds the in-flight address so it stays put while a redirected PC drains
  always_ff @(posedge clk or negedge res) begin
    if (!res)                    r_drain_addr <= 32'h0;
    else if (r_state == S_FETCH) r_drain_addr <= pc_cur;
  end

  // Boot write is suppressed while reset is held so the PC port reads idle
  assign pc_write        = w_pc_write & res;
  assign pc_next         = res ? w_pc_next : 32'h0;
  assign misalign_err    = w_misalign;
  assign fetch_count     = r_fetch_count;
  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : pc_cur;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_sequencer
//  Purpose  : Self-checking bench: directed scenarios plus random traffic,
//             transaction-level reference model and output scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam logic [31:0] c_RV = 32'h0000_0000;
  localparam logic [31:0] c_TV = 32'h0000_0100;

  logic        clk;
  logic        res;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        misalign_err;
  logic        halt;
  logic [31:0] fetch_count;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(
    .RESET_VECTOR (c_RV),
    .TRAP_VECTOR  (c_TV),
    .INSTR_BYTES  (32'd4)
  ) dut (
    .clk             (clk),
    .res             (res),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .pc_write        (pc_write),
    .bus             (bus),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .misalign_err    (misalign_err),
    .halt            (halt),
    .fetch_count     (fetch_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The PC register this block steers
  always @(posedge clk or negedge res) begin
    if (!res)          pc_cur <= 32'h0;
    else if (pc_write) pc_cur <= pc_next;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard queues
  logic [31:0] exp_pcw[$];
  logic [63:0] exp_dlv[$];

  // Reference model: PC value, whether a request is expected, whether the
  // outstanding request belongs to an abandoned PC, and the word held for decode
  logic        m_boot, m_busy, m_stale, m_held;
  logic [31:0] m_pc, m_stale_addr, m_hold_pc, m_hold_data, m_count;
  logic        preset_pending;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict this cycle's outputs from the rules, then advance the model
  task automatic model_step();
    logic        flush, mis, ack, wr;
    logic [31:0] wr_val, exp_addr;
    ack      = bus.imem_ack;
    flush    = !m_boot && (trap || redirect_valid);
    mis      = flush && !trap && (redirect_target[1:0] != 2'b00);
    exp_addr = m_stale ? m_stale_addr : m_pc;
    chk1("imem_req", bus.imem_req, m_busy);
    if (m_busy) chk32("imem_addr", bus.imem_addr, exp_addr);
    chk1("instr_valid", bus.instr_valid, m_held);
    if (m_held) begin
      chk32("instr_hold", bus.instr, m_hold_data);
      chk32("instr_pc_hold", bus.instr_pc, m_hold_pc);
    end
    chk1("misalign_err", misalign_err, mis);
    chk32("fetch_count", fetch_count, m_count);

    wr = 1'b0;
    wr_val = 32'h0;
    if (m_boot) begin
      wr = 1'b1; wr_val = c_RV;
    end else if (flush) begin
      wr = 1'b1; wr_val = (trap || mis) ? c_TV : redirect_target;
    end else if (m_busy && !m_stale && ack) begin
      wr = 1'b1; wr_val = m_pc + 32'd4;
    end
    if (wr) exp_pcw.push_back(wr_val);

    if (m_boot) begin
      m_boot = 1'b0;
      m_busy = !halt;
    end else if (flush) begin
      if (m_busy && !ack) begin
        if (!m_stale) begin
          m_stale = 1'b1;
          m_stale_addr = m_pc;
        end
      end else if (m_busy) begin
        m_stale = 1'b0;
      end else begin
        m_busy = !halt;
      end
      m_held = 1'b0;
    end else if (m_busy && ack) begin
      if (m_stale) m_stale = 1'b0;
      else begin
        m_held = 1'b1;
        m_hold_pc = m_pc;
        m_hold_data = bus.imem_rdata;
        m_busy = 1'b0;
      end
    end else if (m_held && bus.instr_ready) begin
      exp_dlv.push_back({m_hold_pc, m_hold_data});
      m_held = 1'b0;
      m_count = m_count + 32'd1;
      m_busy = !halt;
    end else if (!m_busy && !m_held && !halt) begin
      m_busy = 1'b1;
    end
    if (wr) m_pc = wr_val;
  endtask

  // One clock of stimulus; ack only answers a live request
  task automatic cycle(input logic ack_i, input logic [31:0] rd, input logic rdy,
                       input logic rv, input logic [31:0] tgt, input logic trp,
                       input logic hlt);
    @(negedge clk);
    if (preset_pending) begin
      dut.r_fetch_count = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      preset_pending = 1'b0;
    end
    bus.imem_ack    = ack_i & bus.imem_req;
    bus.imem_rdata  = rd;
    bus.instr_ready = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    trap            = trp;
    halt            = hlt;
    #1;
    model_step();
  endtask

  task automatic apply_reset();
    res = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0; trap = 1'b0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_imem_req", bus.imem_req, 1'b0);
    chk1("rst_instr_valid", bus.instr_valid, 1'b0);
    chk1("rst_pc_write", pc_write, 1'b0);
    chk32("rst_pc_next", pc_next, 32'h0);
    chk32("rst_instr", bus.instr, 32'h0);
    chk32("rst_instr_pc", bus.instr_pc, 32'h0);
    chk32("rst_fetch_count", fetch_count, 32'h0);
    chk1("rst_misalign", misalign_err, 1'b0);
    m_boot = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0;
    m_pc = 32'h0; m_stale_addr = 32'h0; m_hold_pc = 32'h0; m_hold_data = 32'h0;
    m_count = 32'h0; preset_pending = 1'b0;
    exp_pcw.delete();
    exp_dlv.delete();
    @(posedge clk);
    #1;
    res = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT writes the PC or hands off a word
  initial begin
    logic [31:0] e;
    logic [63:0] d;
    forever begin
      @(negedge clk);
      #2;
      if (res) begin
        if (pc_write === 1'b1) begin
          if (exp_pcw.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL pc_write_unexpected: got pc_next %h expected no write at %0t", pc_next, $time);
          end else begin
            e = exp_pcw.pop_front();
            chk32("pc_next", pc_next, e);
          end
        end
        if (bus.instr_valid && bus.instr_ready && !(trap || redirect_valid)) begin
          if (exp_dlv.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL deliver_unexpected: got instr %h at %h expected none at %0t",
                     bus.instr, bus.instr_pc, $time);
          end else begin
            d = exp_dlv.pop_front();
            chk32("deliver_pc", bus.instr_pc, d[63:32]);
            chk32("deliver_instr", bus.instr, d[31:0]);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hlt_r;
    logic [31:0] tgt_r;
    res = 1'b0;
    apply_reset();

    // Boot, ack on third request cycle, immediate accept
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);
    cycle(1, 32'hA000_0001, 1, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);

    // Decode stalls for five cycles
    cycle(1, 32'hB000_0002, 0, 0, 32'h0, 0, 0);
    repeat (5) cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);

    // Redirect while a request is in flight, late ack is drained
    cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 0, 1, 32'h40, 0, 0);
    cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    cycle(1, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 0);
    cycle(1, 32'hC000_0003, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);

    // Trap beats redirect; misaligned redirect becomes a trap
    cycle(0, 32'h0, 0, 1, 32'h80, 1, 0);
    cycle(1, 32'h1111_1111, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 0, 1, 32'h42, 0, 0);
    cycle(1, 32'h2222_2222, 0, 0, 32'h0, 0, 0);
    cycle(1, 32'hD000_0004, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);

    // PC increment wraps; counter wraps
    cycle(0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    cycle(1, 32'h3333_3333, 0, 0, 32'h0, 0, 0);
    cycle(1, 32'hE000_0005, 0, 0, 32'h0, 0, 0);
    preset_pending = 1'b1;
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);

    // Halt after issue parks the fetcher; redirect still lands
    cycle(1, 32'hF000_0006, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 1);
    repeat (3) cycle(0, 32'h0, 0, 0, 32'h0, 0, 1);
    cycle(0, 32'h0, 0, 1, 32'h200, 0, 1);
    cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    cycle(1, 32'h1234_5678, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 1, 0, 32'h0, 0, 0);

    // Reset asserted in the middle of a fetch
    cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    #2;
    res = 1'b0;
    #1;
    chk1("midrst_fetch_req", bus.imem_req, 1'b0);
    chk1("midrst_fetch_valid", bus.instr_valid, 1'b0);
    chk1("midrst_fetch_pcw", pc_write, 1'b0);
    apply_reset();

    // Reset asserted while an instruction is held for decode
    cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    cycle(1, 32'h5555_AAAA, 0, 0, 32'h0, 0, 0);
    cycle(0, 32'h0, 0, 0, 32'h0, 0, 0);
    #2;
    res = 1'b0;
    #1;
    chk1("midrst_issue_valid", bus.instr_valid, 1'b0);
    chk32("midrst_issue_instr", bus.instr, 32'h0);
    apply_reset();

    // Random traffic
    hlt_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) hlt_r = ~hlt_r;
      tgt_r = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 3) == 0) tgt_r[1:0] = 2'($urandom_range(1, 3));
      cycle(($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 11) == 0), tgt_r, ($urandom_range(0, 24) == 0), hlt_r);
    end

    #5;
    chk32("pcw_queue_empty", 32'(exp_pcw.size()), 32'h0);
    chk32("dlv_queue_empty", 32'(exp_dlv.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
